// File: rtl/mac_array_pkg.sv
// Shared types and default sizing for the MAC array job sequencer.
package mac_array_pkg;

    localparam int DEF_D_W     = 8;
    localparam int DEF_D_W_ACC = 16;
    localparam int DEF_N       = 3;
    localparam int DEF_K_MAX   = 16;
    localparam int DEF_MAC_LAT = 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        OUT
    } seq_state_t;

endpackage

// File: rtl/mac_array_seq.sv
// Job sequencer for the N-lane MAC array: feeds operand beats into the array,
// waits for the array pipeline to drain, then presents the accumulated results.
module mac_array_seq
    import mac_array_pkg::*;
#(
    parameter int D_W     = DEF_D_W,
    parameter int D_W_ACC = DEF_D_W_ACC,
    parameter int N       = DEF_N,
    parameter int K_MAX   = DEF_K_MAX,
    parameter int MAC_LAT = DEF_MAC_LAT,
    parameter int LEN_W   = $clog2(K_MAX + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N-1:0][D_W-1:0]       in_a,
    input  logic [N-1:0][D_W-1:0]       in_b,
    input  logic [LEN_W-1:0]            cfg_len,
    output logic [N-1:0][D_W-1:0]       arr_a,
    output logic [N-1:0][D_W-1:0]       arr_b,
    output logic                        arr_init,
    input  logic [N-1:0][D_W_ACC-1:0]   arr_result,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N-1:0][D_W_ACC-1:0]   out_data,
    output logic                        busy
);

    // Wide enough to hold the final drain count MAC_LAT.
    localparam int DRAIN_W = $clog2(MAC_LAT + 2);

    seq_state_t         state;
    seq_state_t         state_next;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   beat_cnt;
    logic [LEN_W-1:0]   first_len;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               accept;
    logic               capture;

    // Effective job length from the first beat: 0 means 1, clamp to K_MAX.
    always_comb begin
        if (cfg_len == '0) begin
            first_len = LEN_W'(1);
        end else if (cfg_len > LEN_W'(K_MAX)) begin
            first_len = LEN_W'(K_MAX);
        end else begin
            first_len = cfg_len;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                accept   = in_valid && !rst;
                if (accept) begin
                    state_next = (first_len == LEN_W'(1)) ? DRAIN : RUN;
                end
            end
            RUN: begin
                in_ready = !rst;
                accept   = in_valid && !rst;
                if (accept && ((beat_cnt + LEN_W'(1)) == len)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_W'(MAC_LAT)) begin
                    capture    = 1'b1;
                    state_next = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Array drive, job counters and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            arr_a     <= '0;
            arr_b     <= '0;
            arr_init  <= 1'b0;
            len       <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            // Zero operands on non-accepting edges keep the accumulators unchanged.
            arr_a    <= accept ? in_a : '0;
            arr_b    <= accept ? in_b : '0;
            arr_init <= accept && (state == IDLE);

            if (accept) begin
                if (state == IDLE) begin
                    len      <= first_len;
                    beat_cnt <= LEN_W'(1);
                end else begin
                    beat_cnt <= beat_cnt + LEN_W'(1);
                end
            end

            if (state != DRAIN) begin
                drain_cnt <= '0;
            end else if (!capture) begin
                drain_cnt <= drain_cnt + DRAIN_W'(1);
            end

            if (capture) begin
                out_data  <= arr_result;
                out_valid <= 1'b1;
            end else if ((state == OUT) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_array_seq.sv
// Self-checking bench for mac_array_seq with a behavioural MAC array attached.
module tb_mac_array_seq;

    localparam int D_W     = 8;
    localparam int D_W_ACC = 16;
    localparam int N       = 3;
    localparam int K_MAX   = 16;
    localparam int MAC_LAT = 1;
    localparam int LEN_W   = $clog2(K_MAX + 1);

    typedef logic [N-1:0][D_W-1:0]     lane_t;
    typedef logic [N-1:0][D_W_ACC-1:0] res_t;

    typedef struct {
        int    cfg;
        int    nb;
        int    bub;
        int    hold;
        lane_t a [4];
        lane_t b [4];
        res_t  exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    lane_t      in_a = '0;
    lane_t      in_b = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    lane_t      arr_a;
    lane_t      arr_b;
    logic       arr_init;
    res_t       arr_result;
    logic       out_valid;
    logic       out_ready = 1'b0;
    res_t       out_data;
    logic       busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mac_array_seq #(
        .D_W(D_W), .D_W_ACC(D_W_ACC), .N(N), .K_MAX(K_MAX), .MAC_LAT(MAC_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .cfg_len(cfg_len),
        .arr_a(arr_a), .arr_b(arr_b), .arr_init(arr_init),
        .arr_result(arr_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    // MAC array stand-in: registers once, initialize loads, otherwise accumulates.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                arr_result[i] <= '0;
            end else if (arr_init) begin
                arr_result[i] <= D_W_ACC'(arr_a[i]) * D_W_ACC'(arr_b[i]);
            end else begin
                arr_result[i] <= arr_result[i] + D_W_ACC'(arr_a[i]) * D_W_ACC'(arr_b[i]);
            end
        end
    end

    function automatic lane_t mk_l(input int x0, input int x1, input int x2);
        lane_t v;
        v[0] = D_W'(x0);
        v[1] = D_W'(x1);
        v[2] = D_W'(x2);
        return v;
    endfunction

    function automatic res_t mk_r(input int x0, input int x1, input int x2);
        res_t v;
        v[0] = D_W_ACC'(x0);
        v[1] = D_W_ACC'(x1);
        v[2] = D_W_ACC'(x2);
        return v;
    endfunction

    function automatic int ref_len(input int cfg);
        if (cfg == 0) return 1;
        if (cfg > K_MAX) return K_MAX;
        return cfg;
    endfunction

    // Per-lane dot product of the job's beats, reduced mod 2^D_W_ACC.
    function automatic res_t ref_mac(input lane_t a [16], input lane_t b [16], input int n);
        res_t r;
        for (int l = 0; l < N; l++) begin
            longint unsigned s = 0;
            for (int k = 0; k < n; k++) begin
                s += longint'(a[k][l]) * longint'(b[k][l]);
            end
            r[l] = D_W_ACC'(s % (longint'(1) << D_W_ACC));
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send_beat(input lane_t a, input lane_t b, input int cfg, input string tag);
        int k = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        cfg_len  = LEN_W'(cfg);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check({tag, " in_ready wait"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = lane_t'($urandom);
        in_b     = lane_t'($urandom);
    endtask

    // Waits for the result, checks latency and data, holds it, then consumes it.
    task automatic wait_out(input res_t exp, input int hold, input string tag);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " out_valid"}, 64'(out_valid), 64'd1);
        check({tag, " latency"}, 64'(n + 1), 64'(2 + MAC_LAT));
        check({tag, " out_data"}, 64'(out_data), 64'(exp));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, " hold out_valid"}, 64'(out_valid), 64'd1);
            check({tag, " hold out_data"}, 64'(out_data), 64'(exp));
            check({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
            check({tag, " hold busy"}, 64'(busy), 64'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " out_valid drop"}, 64'(out_valid), 64'd0);
        check({tag, " idle"}, 64'(busy), 64'd0);
    endtask

    task automatic run_job(input int cfg, input int nb, input int bub, input int hold,
                           input lane_t a [16], input lane_t b [16], input res_t exp,
                           input string tag);
        for (int i = 0; i < nb; i++) begin
            send_beat(a[i], b[i], (i == 0) ? cfg : int'($urandom_range(0, 31)), tag);
            check({tag, " arr_a"}, 64'(arr_a), 64'(a[i]));
            check({tag, " arr_b"}, 64'(arr_b), 64'(b[i]));
            check({tag, " arr_init"}, 64'(arr_init), 64'(i == 0));
            if (i < nb - 1) begin
                for (int j = 0; j < bub; j++) begin
                    @(negedge clk);
                    check({tag, " bubble arr"}, {15'd0, arr_init, arr_a, arr_b}, 64'd0);
                end
            end
        end
        check({tag, " in_ready after last"}, 64'(in_ready), 64'd0);
        wait_out(exp, hold, tag);
    endtask

    vec_t  vecs [5];
    lane_t ja [16];
    lane_t jb [16];

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{cfg: 3, nb: 3, bub: 0, hold: 0,
                    a: '{mk_l(1, 2, 3), mk_l(4, 5, 6), mk_l(7, 8, 9), mk_l(0, 0, 0)},
                    b: '{mk_l(1, 1, 1), mk_l(1, 1, 1), mk_l(1, 1, 1), mk_l(0, 0, 0)},
                    exp: mk_r(12, 15, 18)};
        vecs[1] = '{cfg: 3, nb: 3, bub: 2, hold: 5,
                    a: '{mk_l(1, 2, 3), mk_l(4, 5, 6), mk_l(7, 8, 9), mk_l(0, 0, 0)},
                    b: '{mk_l(1, 1, 1), mk_l(1, 1, 1), mk_l(1, 1, 1), mk_l(0, 0, 0)},
                    exp: mk_r(12, 15, 18)};
        vecs[2] = '{cfg: 1, nb: 1, bub: 0, hold: 0,
                    a: '{mk_l(2, 2, 2), mk_l(0, 0, 0), mk_l(0, 0, 0), mk_l(0, 0, 0)},
                    b: '{mk_l(3, 3, 3), mk_l(0, 0, 0), mk_l(0, 0, 0), mk_l(0, 0, 0)},
                    exp: mk_r(6, 6, 6)};
        vecs[3] = '{cfg: 2, nb: 2, bub: 1, hold: 1,
                    a: '{mk_l(255, 1, 2), mk_l(255, 1, 2), mk_l(0, 0, 0), mk_l(0, 0, 0)},
                    b: '{mk_l(255, 3, 4), mk_l(255, 3, 4), mk_l(0, 0, 0), mk_l(0, 0, 0)},
                    exp: mk_r(64514, 6, 16)};
        vecs[4] = '{cfg: 0, nb: 1, bub: 0, hold: 2,
                    a: '{mk_l(5, 6, 7), mk_l(0, 0, 0), mk_l(0, 0, 0), mk_l(0, 0, 0)},
                    b: '{mk_l(2, 2, 2), mk_l(0, 0, 0), mk_l(0, 0, 0), mk_l(0, 0, 0)},
                    exp: mk_r(10, 12, 14)};

        // Reset state
        rst = 1'b1;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("reset in_ready", 64'(in_ready), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_data", 64'(out_data), 64'd0);
        check("reset arr", {15'd0, arr_init, arr_a, arr_b}, 64'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("post-reset in_ready", 64'(in_ready), 64'd1);

        // Directed job table
        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < 16; k++) begin
                ja[k] = (k < 4) ? vecs[v].a[k] : '0;
                jb[k] = (k < 4) ? vecs[v].b[k] : '0;
            end
            run_job(vecs[v].cfg, vecs[v].nb, vecs[v].bub, vecs[v].hold, ja, jb,
                    vecs[v].exp, $sformatf("vec%0d", v));
        end

        // Reset in the middle of RUN
        send_beat(mk_l(9, 9, 9), mk_l(9, 9, 9), 4, "abort");
        send_beat(mk_l(8, 8, 8), mk_l(8, 8, 8), 4, "abort");
        check("abort busy before rst", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("abort in_ready in rst", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort in_ready", 64'(in_ready), 64'd1);
        begin
            int seen = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            check("abort no out_valid", 64'(seen), 64'd0);
        end
        for (int k = 0; k < 16; k++) begin
            ja[k] = '0;
            jb[k] = '0;
        end
        ja[0] = mk_l(1, 1, 1);
        jb[0] = mk_l(1, 1, 1);
        run_job(1, 1, 0, 0, ja, jb, mk_r(1, 1, 1), "after abort");

        // cfg_len above K_MAX with valid held: count accepted beats
        begin
            int cnt = 0;
            in_valid = 1'b1;
            in_a = mk_l(1, 1, 1);
            in_b = mk_l(1, 1, 1);
            cfg_len = LEN_W'(20);
            for (int c = 0; c < 40; c++) begin
                if (!in_ready) break;
                cnt++;
                @(negedge clk);
                cfg_len = LEN_W'($urandom_range(0, 31));
            end
            in_valid = 1'b0;
            check("clamp beats accepted", 64'(cnt), 64'(K_MAX));
            wait_out(mk_r(16, 16, 16), 0, "clamp");
        end

        // Randomized jobs against the reference dot product
        for (int r = 0; r < 12; r++) begin
            int cfg;
            int nb;
            cfg = int'($urandom_range(0, 20));
            nb  = ref_len(cfg);
            for (int k = 0; k < 16; k++) begin
                ja[k] = (k < nb) ? lane_t'($urandom) : '0;
                jb[k] = (k < nb) ? lane_t'($urandom) : '0;
            end
            run_job(cfg, nb, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                    ja, jb, ref_mac(ja, jb, nb), $sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_array_seq.md
Name: mac_array_seq

Overview:
Job sequencer for the N-lane MAC array. It accepts a stream of operand beats over a valid/ready handshake and drives the array's a/b/initialize inputs. It asserts initialize on the first beat of each job and drives zero operands on bubble cycles so the accumulators hold their value. After the pipeline drains, it captures the N accumulator results and presents them on a valid/ready output port. It sits between the operand source and the array; the parent connects arr_* to the array instance, which shares clk/rst.

Parameters:
D_W, 8, operand width
D_W_ACC, 16, accumulator/result width
N, 3, number of lanes
K_MAX, 16, maximum beats per job
MAC_LAT, 1, cycles from array input to updated result (array registers once)
LEN_W, $clog2(K_MAX+1), width of cfg_len

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  sequencer accepts beat
in_a  input  D_W x [N-1:0]  per-lane operand a
in_b  input  D_W x [N-1:0]  per-lane operand b
cfg_len  input  LEN_W  beats in job; sampled with first beat only
arr_a  output  D_W x [N-1:0]  to array a
arr_b  output  D_W x [N-1:0]  to array b
arr_init  output  1  to array initialize
arr_result  input  D_W_ACC x [N-1:0]  from array result
out_valid  output  1  result vector valid
out_ready  input  1  consumer accepts result
out_data  output  D_W_ACC x [N-1:0]  captured results
busy  output  1  state != IDLE

Behaviour:
- Clock/reset: one clock clk; rst synchronous active-high. In reset: state IDLE; arr_a/arr_b/arr_init/out_valid/out_data/counters = 0; in_ready = 0 while rst is high.
- Handshake: a beat is accepted on any cycle where in_valid && in_ready. out_data transfers when out_valid && out_ready.
- arr_a, arr_b and arr_init are registered. On the edge after an accepted beat they carry that beat's operands. On every non-accepting edge: arr_a = arr_b = 0 and arr_init = 0, so no accumulation is disturbed.
- Array contract: initialize=1 loads a*b; otherwise result += a*b. Arithmetic wraps mod 2^D_W_ACC.
- FSM states:
  - IDLE: in_ready=1. On accept: latch len = (cfg_len==0) ? 1 : min(cfg_len, K_MAX); arr_init<=1; beat_cnt<=1. Go to DRAIN if len==1, else RUN.
  - RUN: in_ready=1. On accept: beat_cnt++, arr_init<=0. When the accepted beat is number len, go to DRAIN. Bubbles (in_valid=0) are allowed and unbounded.
  - DRAIN: in_ready=0. drain_cnt counts MAC_LAT+1 cycles. On the final DRAIN edge: out_data <= arr_result, out_valid <= 1, go to OUT.
  - OUT: in_ready=0, out_valid=1, out_data held stable. On out_ready: out_valid <= 0, go to IDLE.
- Latency: last beat accepted in cycle t gives out_valid high in cycle t+2+MAC_LAT (t+3 at default).
- No job overlap: a new job's first beat is accepted no earlier than the cycle after the out handshake.
- cfg_len is ignored on non-first beats.
- rst mid-job (any state): job aborted, no out_valid, pending data discarded. The array is cleared by the shared rst.
- in_a/in_b are don't-care when no accept occurs.

Decomposition:
- Package mac_array_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} seq_state_t
  - localparam defaults for D_W, D_W_ACC, N, K_MAX
- No sub-module is needed: a single FSM plus two counters. A bench-level wrapper instantiates mac_array_seq together with the array.

Test Plan:
- Back-to-back: len=3, in_a beats {1,2,3},{4,5,6},{7,8,9}, in_b all {1,1,1}, in_valid held high -> out_data={12,15,18}; out_valid rises 3 cycles after the 3rd handshake; arr_init high only for beat 1.
- Bubbles: same job with in_valid low for 2 cycles between each beat -> arr_a/arr_b=0 during bubbles; out_data={12,15,18}.
- Back-pressure and restart: hold out_ready low for 5 cycles -> out_data stable, in_ready=0, busy=1. Then job len=1, a={2,2,2}, b={3,3,3} -> out_data={6,6,6}, proving initialize discards the old sum.
- Wrap: len=2, lane0 a=255, b=255 on both beats -> out_data[0]=130050 mod 65536 = 64514.
- Reset mid-RUN: rst for 1 cycle after 2 of 4 beats -> no out_valid, state IDLE. Next job len=1, a=b={1,1,1} -> {1,1,1}.
- Length edge cases: cfg_len=0 -> treated as 1. cfg_len=20 with K_MAX=16 -> exactly 16 beats accepted before in_ready drops.
